// File: rtl/match_logger.sv
`default_nettype none
// ============================================================================
// Module   : match_logger
// Brief    : Counts rising edges of a match signal and logs their timestamps
//            into a small FIFO that is drained through a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module match_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   match_in,
  input  logic                   en,
  input  logic                   clr,
  output logic                   ts_valid,
  input  logic                   ts_ready,
  output logic [TS_W-1:0]        ts_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       match_cnt,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [TS_W-1:0]  r_ts;
  logic             r_prev;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [TS_W-1:0]  r_mem [DEPTH];

  logic w_event;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_event = match_in & ~r_prev & en;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = ~w_empty & ts_ready & ~clr;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push  = w_event & ~clr & (~w_full | w_pop);
  assign w_drop  = w_event & ~clr & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= match_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ts <= '0;
    end else if (clr) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else if (clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_event && !(&r_cnt)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Storage carries no reset; stale contents are masked by the empty gate.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= r_ts;
    end
  end

  assign ts_valid  = ~w_empty;
  assign ts_data   = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign level     = r_wptr - r_rptr;
  assign match_cnt = r_cnt;
  assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_match_logger.sv
`default_nettype none
// ============================================================================
// Module   : tb_match_logger
// Brief    : Self-checking bench for match_logger (default and small configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_match_logger;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic match_in = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic ts_ready = 1'b0;

  logic        v0;
  logic [15:0] d0;
  logic [2:0]  l0;
  logic [7:0]  c0;
  logic        o0;
  logic        v1;
  logic [3:0]  d1;
  logic [1:0]  l1;
  logic [1:0]  c1;
  logic        o1;

  int n_total = 0;
  int n_pass  = 0;
  int last;
  int exp_a[4];

  // Reference model: per configuration k, an ordered list of held entries.
  int m_ts[2];
  int m_cnt[2];
  int m_ovf[2];
  int m_n[2];
  int m_q[2][16];
  int m_prev;

  always #5 clk = ~clk;

  match_logger u_dut (
    .clk(clk), .rstn(rstn), .match_in(match_in), .en(en), .clr(clr),
    .ts_valid(v0), .ts_ready(ts_ready), .ts_data(d0), .level(l0),
    .match_cnt(c0), .overflow(o0)
  );

  match_logger #(.TS_W(4), .DEPTH(2), .CNT_W(2)) u_sml (
    .clk(clk), .rstn(rstn), .match_in(match_in), .en(en), .clr(clr),
    .ts_valid(v1), .ts_ready(ts_ready), .ts_data(d1), .level(l1),
    .match_cnt(c1), .overflow(o1)
  );

  function automatic int ts_mod(input int k);
    return (k == 0) ? 65536 : 16;
  endfunction

  function automatic int cnt_max(input int k);
    return (k == 0) ? 255 : 3;
  endfunction

  function automatic int depth(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ts[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_n[k] = 0;
    end
    m_prev = 0;
  endtask

  task automatic model_step();
    bit ev;
    if (!rstn) begin
      model_reset();
      return;
    end
    ev = match_in && !m_prev && en;
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        m_n[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_ts[k] = 0;
      end else begin
        if (m_n[k] > 0 && ts_ready) begin
          for (int i = 1; i < m_n[k]; i++) m_q[k][i-1] = m_q[k][i];
          m_n[k]--;
        end
        if (ev) begin
          if (m_cnt[k] < cnt_max(k)) m_cnt[k]++;
          if (m_n[k] < depth(k)) begin
            m_q[k][m_n[k]] = m_ts[k];
            m_n[k]++;
          end else begin
            m_ovf[k] = 1;
          end
        end
        m_ts[k] = (m_ts[k] + 1) % ts_mod(k);
      end
    end
    m_prev = match_in ? 1 : 0;
  endtask

  task automatic compare_all();
    check("valid0", v0, (m_n[0] != 0) ? 1 : 0);
    check("data0",  d0, (m_n[0] != 0) ? m_q[0][0] : 0);
    check("level0", l0, m_n[0]);
    check("cnt0",   c0, m_cnt[0]);
    check("ovf0",   o0, m_ovf[0]);
    check("valid1", v1, (m_n[1] != 0) ? 1 : 0);
    check("data1",  d1, (m_n[1] != 0) ? m_q[1][0] : 0);
    check("level1", l1, m_n[1]);
    check("cnt1",   c1, m_cnt[1]);
    check("ovf1",   o1, m_ovf[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wait_ts(input int t);
    int guard;
    guard = 0;
    while (m_ts[0] != t && guard < 200) begin
      cycle();
      guard++;
    end
    if (guard >= 200) check("wait_ts_timeout", m_ts[0], t);
  endtask

  task automatic pulse_at(input int t);
    wait_ts(t);
    match_in = 1'b1;
    cycle();
    match_in = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  task automatic pop_one();
    ts_ready = 1'b1;
    cycle();
    ts_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    #2;
    rstn = 1'b0;
    #1;
    compare_all();
    cycle();
    cycle();
    // Match already high in the first cycle out of reset is an event at ts=0.
    rstn = 1'b1;
    en = 1'b1;
    match_in = 1'b1;
    cycle();
    match_in = 1'b0;
    check("first_evt_level", l0, 1);
    check("first_evt_cnt", c0, 1);
    pop_one();

    do_clr();
    pulse_at(5);
    check("pulse_valid", v0, 1);
    check("pulse_data", d0, 5);
    check("pulse_level", l0, 1);
    check("pulse_cnt", c0, 1);
    pop_one();
    check("pop_valid", v0, 0);
    check("pop_data", d0, 0);

    wait_ts(10);
    match_in = 1'b1;
    repeat (4) cycle();
    match_in = 1'b0;
    cycle();
    check("hold_level", l0, 1);
    check("hold_data", d0, 10);
    check("hold_cnt", c0, 2);
    en = 1'b0;
    pulse_at(20);
    cycle();
    check("dis_cnt", c0, 2);
    check("dis_level", l0, 1);
    en = 1'b1;
    pop_one();

    do_clr();
    pulse_at(2); pulse_at(5); pulse_at(8); pulse_at(11); pulse_at(14); pulse_at(17);
    cycle();
    check("ovf_level", l0, 4);
    check("ovf_flag", o0, 1);
    check("ovf_cnt", c0, 6);
    check("sat_cnt_small", c1, 3);
    exp_a[0] = 2; exp_a[1] = 5; exp_a[2] = 8; exp_a[3] = 11;
    for (int i = 0; i < 4; i++) begin
      check("drain_data", d0, exp_a[i]);
      pop_one();
    end
    check("drain_empty", v0, 0);

    do_clr();
    pulse_at(2); pulse_at(5); pulse_at(8); pulse_at(11);
    wait_ts(20);
    match_in = 1'b1;
    ts_ready = 1'b1;
    cycle();
    match_in = 1'b0;
    ts_ready = 1'b0;
    check("fullpop_level", l0, 4);
    check("fullpop_ovf", o0, 0);
    last = -1;
    for (int i = 0; i < 4; i++) begin
      last = d0;
      pop_one();
    end
    check("fullpop_last", last, 20);

    do_clr();
    pulse_at(14);
    pulse_at(17);
    check("wrap_first", d1, 14);
    pop_one();
    check("wrap_second", d1, 1);
    pop_one();

    do_clr();
    pulse_at(2); pulse_at(5); pulse_at(8);
    check("pre_clr_level1", l1, 2);
    check("pre_clr_ovf1", o1, 1);
    wait_ts(11);
    match_in = 1'b1;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    match_in = 1'b0;
    check("clr_level0", l0, 0);
    check("clr_level1", l1, 0);
    check("clr_cnt1", c1, 0);
    check("clr_ovf1", o1, 0);
    cycle();
    pulse_at(3);
    check("clr_ts_restart", d0, 3);

    do_clr();
    pulse_at(2); pulse_at(5); pulse_at(8);
    ts_ready = 1'b1;
    cycle();
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("async_rst_level", l0, 0);
    ts_ready = 1'b0;
    cycle();
    cycle();
    rstn = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      match_in = ($urandom_range(0, 3) == 0);
      en       = ($urandom_range(0, 7) != 0);
      ts_ready = ($urandom_range(0, 2) == 0);
      clr      = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
